// File: rtl/mux41_scan.sv
// Round-robin scanner driving the select lines of a 4:1 mux.
// Each granted channel is held for up to DWELL cycles, or until its request drops.
module mux41_scan #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       s0,
  output logic       s1,
  output logic [3:0] gnt,
  output logic       vld,
  output logic       sw
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       vld_q, vld_d;
  logic       sw_q, sw_d;
  logic [1:0] pick_s;
  logic       grant_end_s;
  logic       new_grant_s;

  // First requester after `last`; `last` itself is tried only as the final candidate.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] ch;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      ch = last + 2'(k);
      if (r[ch]) begin
        rr_pick = ch;
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    vld_d       = vld_q;
    sw_d        = 1'b0;
    new_grant_s = 1'b0;
    pick_s      = rr_pick(req, last_q);
    // In HOLD, last_q is the channel currently granted.
    grant_end_s = (cnt_q == 8'd0) || !req[last_q];

    case (state_q)
      IDLE: begin
        if (|req) begin
          new_grant_s = 1'b1;
        end else begin
          vld_d = 1'b0;
          gnt_d = 4'b0000;
        end
      end
      HOLD: begin
        if (grant_end_s) begin
          if (|req) begin
            new_grant_s = 1'b1;
          end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
            gnt_d   = 4'b0000;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        gnt_d   = 4'b0000;
      end
    endcase

    if (new_grant_s) begin
      state_d = HOLD;
      cnt_d   = DWELL_M1;
      last_d  = pick_s;
      sel_d   = pick_s;
      gnt_d   = 4'b0001 << pick_s;
      vld_d   = 1'b1;
      sw_d    = 1'b1;
    end else begin
      sw_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 2'd3;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      sw_q    <= sw_d;
    end
  end

  assign s0  = sel_q[1];
  assign s1  = sel_q[0];
  assign gnt = gnt_q;
  assign vld = vld_q;
  assign sw  = sw_q;

endmodule

// File: tb/tb_mux41_scan.sv
// Bench for mux41_scan: four instances (DWELL 1..4) share one request bus and
// are checked against a cycle-level reference model, a vector table and directed sequences.
module tb_mux41_scan;

  localparam int DW [4] = '{1, 2, 3, 4};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] s0_w, s1_w, vld_w, sw_w;
  logic [3:0] gnt_w [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mux41_scan #(.DWELL(DW[g])) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .s0   (s0_w[g]),
      .s1   (s1_w[g]),
      .gnt  (gnt_w[g]),
      .vld  (vld_w[g]),
      .sw   (sw_w[g])
    );
  end

  // Reference model: owner channel, cycles of dwell remaining, last grant.
  logic       m_busy [4];
  int         m_own  [4];
  int         m_rem  [4];
  int         m_last [4];
  int         m_sel  [4];
  logic       m_sw   [4];

  typedef struct {
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       vld;
    logic       sw;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [7:0] dut_vec(input int g);
    return {s0_w[g], s1_w[g], gnt_w[g], vld_w[g], sw_w[g]};
  endfunction

  function automatic logic [7:0] mk_vec(input int sel, input logic busy, input int own, input logic swv);
    logic [1:0] s;
    logic [3:0] oh;
    s  = 2'(sel);
    oh = busy ? (4'b0001 << own) : 4'b0000;
    return {s, oh, busy, swv};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {s0,s1,gnt,vld,sw}=%b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 4; g++) begin
      m_busy[g] = 1'b0;
      m_own[g]  = 0;
      m_rem[g]  = 0;
      m_last[g] = 3;
      m_sel[g]  = 0;
      m_sw[g]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    int ch;
    logic found;
    for (int g = 0; g < 4; g++) begin
      m_sw[g] = 1'b0;
      if (m_busy[g] && r[m_own[g]] && m_rem[g] > 1) begin
        m_rem[g] = m_rem[g] - 1;
      end else begin
        found = 1'b0;
        ch = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && r[(m_last[g] + k) % 4]) begin
            found = 1'b1;
            ch = (m_last[g] + k) % 4;
          end
        end
        if (found) begin
          m_busy[g] = 1'b1;
          m_own[g]  = ch;
          m_last[g] = ch;
          m_sel[g]  = ch;
          m_rem[g]  = DW[g];
          m_sw[g]   = 1'b1;
        end else begin
          m_busy[g] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    for (int g = 0; g < 4; g++) begin
      chk(name, dut_vec(g), mk_vec(m_sel[g], m_busy[g], m_own[g], m_sw[g]));
    end
  endtask

  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_model("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    check_model("reset_state");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] s;
    model_reset();

    tbl = '{
      '{4'b0001, 2'b00, 4'b0001, 1'b1, 1'b1},
      '{4'b0001, 2'b00, 4'b0001, 1'b1, 1'b0},
      '{4'b0001, 2'b00, 4'b0001, 1'b1, 1'b0},
      '{4'b0001, 2'b00, 4'b0001, 1'b1, 1'b0},
      '{4'b0001, 2'b00, 4'b0001, 1'b1, 1'b1},
      '{4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0},
      '{4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0},
      '{4'b0010, 2'b01, 4'b0010, 1'b1, 1'b1},
      '{4'b1000, 2'b11, 4'b1000, 1'b1, 1'b1},
      '{4'b1001, 2'b11, 4'b1000, 1'b1, 1'b0},
      '{4'b1001, 2'b11, 4'b1000, 1'b1, 1'b0},
      '{4'b1001, 2'b11, 4'b1000, 1'b1, 1'b0},
      '{4'b1001, 2'b00, 4'b0001, 1'b1, 1'b1},
      '{4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0},
      '{4'b0100, 2'b10, 4'b0100, 1'b1, 1'b1},
      '{4'b0000, 2'b10, 4'b0000, 1'b0, 1'b0}
    };

    // Vector table against the DWELL=4 instance
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].req);
      chk($sformatf("table[%0d]", i), dut_vec(3),
          {tbl[i].sel, tbl[i].gnt, tbl[i].vld, tbl[i].sw});
    end

    // All four requesting, DWELL=2: a,b,c,d,a every two cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(4'b1111);
      s = 2'((i / 2) % 4);
      chk("rr_dwell2", dut_vec(1), {s, 4'b0001 << s, 1'b1, (i % 2) == 0});
    end

    // Only c requesting, DWELL=3: re-grant pulses every third cycle
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(4'b0100);
      chk("c_only_dwell3", dut_vec(2), {2'b10, 4'b0100, 1'b1, (i % 3) == 0});
    end

    // DWELL=1 rotates every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1011);
      s = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd1 : 2'd3;
      chk("dwell1_rotate", dut_vec(0), {s, 4'b0001 << s, 1'b1, 1'b1});
    end

    // Asynchronous reset while holding channel d, then a wins first
    do_reset();
    cycle(4'b1000);
    cycle(4'b1000);
    chk("hold_d", dut_vec(3), {2'b11, 4'b1000, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_reset");
    chk("async_reset_d", dut_vec(3), 8'b00_0000_0_0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001);
    chk("after_reset_a", dut_vec(3), {2'b00, 4'b0001, 1'b1, 1'b1});

    // Randomized traffic against the model
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = 4'($urandom_range(0, 15));
      end
      cycle(r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux41_scan.md
MUX41_SCAN -- requirements
Module: mux41_scan

Interface
REQ-001 SHALL have parameter DWELL, default 4, giving the number of cycles one channel stays selected (legal 1..255).
REQ-002 SHALL have input clk, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have input rst_n, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have input req, 4 bits, request per mux channel: req[0]=a, req[1]=b, req[2]=c, req[3]=d.
REQ-005 SHALL have output s0, 1 bit, registered, MSB of the 4:1 mux select.
REQ-006 SHALL have output s1, 1 bit, registered, LSB of the 4:1 mux select.
REQ-007 SHALL have output gnt, 4 bits, registered, one-hot copy of the current selection.
REQ-008 SHALL have output vld, 1 bit, registered, high while a channel is granted.
REQ-009 SHALL have output sw, 1 bit, registered, one-cycle pulse on every new grant.

Function
REQ-010 SHALL encode the selection as {s0,s1}: 00=a, 01=b, 10=c, 11=d, matching the downstream 4:1 mux.
REQ-011 SHALL implement two states: IDLE (no grant) and HOLD (a channel granted).
REQ-012 SHALL keep a 2-bit last-granted pointer; the search order starts at last+1 and wraps 3->0 (round-robin).
REQ-013 SHALL, in IDLE with any req bit set, grant the first requesting channel in search order at the next edge, enter HOLD, and load the dwell counter with DWELL-1.
REQ-014 SHALL, in IDLE with req=0000, stay in IDLE with vld=0 and gnt=0000, and hold s0/s1 at their last values.
REQ-015 SHALL, in HOLD, decrement the dwell counter by 1 per cycle while the granted channel's req bit stays high.
REQ-016 SHALL end the grant when the counter is 0, or when the granted channel's req bit is low, sampled at the same edge.
REQ-017 SHALL, at grant end with another eligible request, switch directly to the next channel in search order with no idle bubble (vld stays 1, sw=1, counter reloaded).
REQ-018 SHALL, at grant end, treat the just-granted channel as eligible again only if no other channel is requesting.
REQ-019 SHALL, at grant end with no requests, return to IDLE with vld=0 and gnt=0000.
REQ-020 SHALL update last-granted on every new grant.
REQ-021 SHALL assert sw for exactly the first cycle of each grant, including a back-to-back re-grant of the same channel.
REQ-022 SHALL, with DWELL=1, grant one cycle per channel, so requesters rotate every cycle.
REQ-023 SHALL keep the dwell counter 8 bits wide and never let it wrap below 0.
REQ-024 SHALL change s0, s1, gnt, vld and sw only together, in the same cycle.

Reset
REQ-025 SHALL, while rst_n=0, force s0=0, s1=0, gnt=0000, vld=0, sw=0, state IDLE, counter 0 and last-granted=3, so channel a has first priority.
REQ-026 SHALL, on reset asserted mid-HOLD, drop the grant immediately without waiting for a clock edge.
REQ-027 SHALL evaluate requests from IDLE on the first rising edge after rst_n deasserts.

Verification
REQ-028 Reset release, req=0001, DWELL=4 -> next edge: {s0,s1}=00, gnt=0001, vld=1, sw=1; grant held 4 cycles.
REQ-029 req=1111, DWELL=2 -> grants rotate a,b,c,d,a with {s0,s1} stepping 00,01,10,11,00 every 2 cycles; sw pulses each step; vld never drops.
REQ-030 Only c requests, DWELL=3, req=0100 held -> {s0,s1}=10 continuously; sw pulses every 3 cycles; vld stays 1.
REQ-031 b granted, req[1] dropped after 1 cycle with req[3]=1 -> next edge: {s0,s1}=11, gnt=1000, sw=1.
REQ-032 Single request a granted, then req->0000 -> next edge: vld=0, gnt=0000, {s0,s1} held at 00.
REQ-033 rst_n pulsed low mid-HOLD on channel d -> outputs at reset values asynchronously; after release with req=1001, channel a is granted first.
